// File: rtl/ic_ddr_unpacker_pkg.sv
// ic_ddr_unpacker_pkg
//   Shared widths and state encodings for the DDR-to-input-cache unpacker.
//   DATA_WIDTH / DDR_WIDTH carry the same values as the legacy
//   Data_width / DDR_width defines.
package ic_ddr_unpacker_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned DDR_WIDTH  = 128;
    localparam int unsigned WPB        = DDR_WIDTH / DATA_WIDTH;

    // One-hot state encoding, kept bit-compatible with the legacy localparams.
    typedef enum logic [1:0] {
        EMPTY  = 2'b01,
        STREAM = 2'b10
    } state_t;

endpackage

// File: rtl/ic_ddr_unpacker.sv
// ic_ddr_unpacker
//   Accepts DDR_WIDTH-bit words over a valid/ready handshake and serialises
//   them, little-endian, into a DATA_WIDTH-bit stream for the input cache
//   write port. The last element of every TILE_BYTES-element tile is marked
//   with wlast / tile_done.
//
// Ports
//   clk        : clock
//   rst        : asynchronous active-high reset
//   ddr_data   : DDR read word
//   ddr_valid  : ddr_data valid
//   ddr_ready  : word can be accepted this cycle (combinational)
//   wrdy       : input cache can take a write
//   din        : element to input cache (registered)
//   wr_en      : din valid (registered)
//   wlast      : din is the last element of a tile (registered)
//   tile_done  : one-cycle pulse with the wlast beat
//   busy       : holding register occupied or wr_en high
module ic_ddr_unpacker #(
    parameter int unsigned DATA_WIDTH = ic_ddr_unpacker_pkg::DATA_WIDTH,
    parameter int unsigned DDR_WIDTH  = ic_ddr_unpacker_pkg::DDR_WIDTH,
    parameter int unsigned TILE_BYTES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DDR_WIDTH-1:0]  ddr_data,
    input  logic                  ddr_valid,
    output logic                  ddr_ready,
    input  logic                  wrdy,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  wr_en,
    output logic                  wlast,
    output logic                  tile_done,
    output logic                  busy
);

    import ic_ddr_unpacker_pkg::*;

    localparam int unsigned ELEMS  = DDR_WIDTH / DATA_WIDTH;
    localparam int unsigned IDX_W  = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam int unsigned TCNT_W = (TILE_BYTES > 1) ? $clog2(TILE_BYTES) : 1;

    state_t                              state_q, state_d;
    logic [IDX_W-1:0]                    idx_q, idx_d;
    logic [TCNT_W-1:0]                   tcnt_q, tcnt_d;
    // Packed element view: hold_q[k] is ddr_data[k*DATA_WIDTH +: DATA_WIDTH].
    logic [ELEMS-1:0][DATA_WIDTH-1:0]    hold_q, hold_d;
    logic [DATA_WIDTH-1:0]               din_q, din_d;
    logic                                wr_en_q, wr_en_d;
    logic                                wlast_q, wlast_d;
    logic                                tile_done_q, tile_done_d;

    logic emit;
    logic last_elem;
    logic tile_last;
    logic accept;

    always_comb begin
        emit      = (state_q == STREAM) && wrdy;
        last_elem = (idx_q == IDX_W'(ELEMS - 1));
        tile_last = (tcnt_q == TCNT_W'(TILE_BYTES - 1));
        // Refill on the same edge the final element leaves: no bubble.
        ddr_ready = (state_q == EMPTY) || (emit && last_elem);
        accept    = ddr_valid && ddr_ready;

        state_d     = state_q;
        idx_d       = idx_q;
        tcnt_d      = tcnt_q;
        hold_d      = hold_q;
        din_d       = din_q;
        wr_en_d     = 1'b0;
        wlast_d     = 1'b0;
        tile_done_d = 1'b0;

        if (emit) begin
            din_d       = hold_q[idx_q];
            wr_en_d     = 1'b1;
            wlast_d     = tile_last;
            tile_done_d = tile_last;
            idx_d       = last_elem ? '0 : idx_q + 1'b1;
            tcnt_d      = tile_last ? '0 : tcnt_q + 1'b1;
            if (last_elem) begin
                state_d = EMPTY;
            end
        end

        // A load overrides the drain-to-EMPTY decision above.
        if (accept) begin
            hold_d  = ddr_data;
            idx_d   = '0;
            state_d = STREAM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            idx_q       <= '0;
            tcnt_q      <= '0;
            hold_q      <= '0;
            din_q       <= '0;
            wr_en_q     <= 1'b0;
            wlast_q     <= 1'b0;
            tile_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tcnt_q      <= tcnt_d;
            hold_q      <= hold_d;
            din_q       <= din_d;
            wr_en_q     <= wr_en_d;
            wlast_q     <= wlast_d;
            tile_done_q <= tile_done_d;
        end
    end

    assign din       = din_q;
    assign wr_en     = wr_en_q;
    assign wlast     = wlast_q;
    assign tile_done = tile_done_q;
    assign busy      = (state_q == STREAM) || wr_en_q;

endmodule

// File: tb/tb_ic_ddr_unpacker.sv
// tb_ic_ddr_unpacker
//   Two instances (TILE_BYTES=64 and 24) share one stimulus stream. The
//   reference model is a byte FIFO: every accepted word pushes its 16 bytes,
//   every cycle with wrdy high and bytes pending pops one. Tile markers come
//   from the total number of bytes emitted since reset.
module tb_ic_ddr_unpacker;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] ddr_data;
    logic         ddr_valid;
    logic         wrdy;

    logic         ready_a, wr_en_a, wlast_a, done_a, busy_a;
    logic [7:0]   din_a;
    logic         ready_b, wr_en_b, wlast_b, done_b, busy_b;
    logic [7:0]   din_b;

    ic_ddr_unpacker #(.DATA_WIDTH(8), .DDR_WIDTH(128), .TILE_BYTES(64)) u_dut (
        .clk(clk), .rst(rst), .ddr_data(ddr_data), .ddr_valid(ddr_valid),
        .ddr_ready(ready_a), .wrdy(wrdy), .din(din_a), .wr_en(wr_en_a),
        .wlast(wlast_a), .tile_done(done_a), .busy(busy_a)
    );

    ic_ddr_unpacker #(.DATA_WIDTH(8), .DDR_WIDTH(128), .TILE_BYTES(24)) u_dut24 (
        .clk(clk), .rst(rst), .ddr_data(ddr_data), .ddr_valid(ddr_valid),
        .ddr_ready(ready_b), .wrdy(wrdy), .din(din_b), .wr_en(wr_en_b),
        .wlast(wlast_b), .tile_done(done_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [7:0]   mq[$];     // bytes accepted but not yet emitted
    logic [127:0] src[$];    // words waiting to be offered
    int unsigned  emitted;   // bytes emitted since reset
    logic [7:0]   last_din;
    bit           gate;      // when 0, ddr_valid is held low

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [127:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic cycle();
        logic         exp_ready;
        bit           acc, emit, l64, l24;
        logic [127:0] w;
        ddr_valid = gate && (src.size() > 0);
        ddr_data  = (src.size() > 0) ? src[0] : '0;
        #1;
        exp_ready = (mq.size() == 0) || (mq.size() == 1 && wrdy);
        check("ddr_ready", ready_a, exp_ready);
        check("ddr_ready24", ready_b, exp_ready);
        acc  = ddr_valid && exp_ready;
        emit = wrdy && (mq.size() > 0);
        l64  = emit && ((emitted % 64) == 63);
        l24  = emit && ((emitted % 24) == 23);
        @(posedge clk);
        #1;
        if (emit) begin
            last_din = mq.pop_front();
            emitted++;
        end
        if (acc) begin
            w = src.pop_front();
            for (int k = 0; k < 16; k++) mq.push_back(w[k*8 +: 8]);
        end
        check("wr_en", wr_en_a, emit);
        check("din", din_a, last_din);
        check("wlast", wlast_a, l64);
        check("tile_done", done_a, l64);
        check("busy", busy_a, (mq.size() > 0) || emit);
        check("wr_en24", wr_en_b, emit);
        check("din24", din_b, last_din);
        check("wlast24", wlast_b, l24);
        check("tile_done24", done_b, l24);
        check("busy24", busy_b, (mq.size() > 0) || emit);
    endtask

    // Asynchronous reset applied away from the clock edge.
    task automatic do_reset();
        rst       = 1'b1;
        ddr_valid = 1'b0;
        #1;
        check("rst_wr_en", wr_en_a, 1'b0);
        check("rst_din", din_a, 8'h00);
        check("rst_busy", busy_a, 1'b0);
        check("rst_wlast", wlast_a, 1'b0);
        check("rst_tile_done", done_a, 1'b0);
        check("rst_ready", ready_a, 1'b1);
        check("rst_wr_en24", wr_en_b, 1'b0);
        check("rst_busy24", busy_b, 1'b0);
        mq.delete();
        src.delete();
        emitted  = 0;
        last_din = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_ready", ready_a, 1'b1);
    endtask

    initial begin
        logic [127:0] pat;
        rst       = 1'b1;
        ddr_valid = 1'b0;
        ddr_data  = '0;
        wrdy      = 1'b0;
        gate      = 1'b0;
        emitted   = 0;
        last_din  = '0;
        #12;
        do_reset();

        // Single known word, full-rate drain.
        pat  = 128'h0F0E0D0C0B0A09080706050403020100;
        src.push_back(pat);
        gate = 1'b1;
        wrdy = 1'b1;
        repeat (20) cycle();

        // Four back-to-back words: one full 64-byte tile.
        do_reset();
        for (int i = 0; i < 4; i++) src.push_back(rand_word());
        repeat (70) cycle();

        // wrdy stall of three cycles after element 5.
        do_reset();
        src.push_back(pat);
        for (int i = 0; i < 30; i++) begin
            wrdy = !(i >= 7 && i < 10);
            cycle();
        end
        wrdy = 1'b1;

        // Reset in the middle of a tile, then a fresh tile.
        do_reset();
        src.push_back(rand_word());
        src.push_back(rand_word());
        repeat (7) cycle();
        do_reset();
        for (int i = 0; i < 5; i++) src.push_back(rand_word());
        repeat (100) cycle();

        // Words separated by 5-cycle ddr_valid gaps; tile spans the gaps.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            src.push_back(rand_word());
            gate = 1'b1;
            repeat (17) cycle();
            gate = 1'b0;
            repeat (5) cycle();
        end

        // Random valid/wrdy mix.
        for (int i = 0; i < 800; i++) begin
            gate = ($urandom_range(0, 3) != 0);
            wrdy = ($urandom_range(0, 4) != 0);
            if (src.size() < 2) src.push_back(rand_word());
            cycle();
        end

        // Drain.
        gate = 1'b0;
        wrdy = 1'b1;
        repeat (40) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
